ssp_cmd_master: RTL and testbench
=================================

// Module: ssp_cmd_master
// PURPOSE
//  RTL initiator for the SSP register bus of ssp_uart (UCR/USR/RDR/TDR/SPR).
//  - Accepts register commands on a valid/ready port.
//  - Sequences SSP_SSEL/SSP_RA/SSP_WnR/SSP_DI/SSP_EOC and captures SSP_DO after a fixed read latency.
//  - Returns a response on a valid/ready port.
//  - Supports read, write, and write-verify (write then read back and compare).
//  - Sits between a host/CPU-side fabric and ssp_uart; replaces bench-only bus driving.
// PARAMETERS
//  RD_LAT   2   Clk cycles after the EOC strobe before SSP_DO is sampled (legal range 1..15)
//  ERRW     8   width of the saturating error counter
// PORTS
//  Clk        in   1      system clock; all logic on rising edge
//  Rst_n      in   1      asynchronous reset, active-low
//  cmd_valid  in   1      command offered
//  cmd_ready  out  1      command accepted when cmd_valid&&cmd_ready
//  cmd_op     in   2      00 read, 01 write, 10 write-verify, 11 reserved (treated as read)
//  cmd_ra     in   3      register address; 0..4 valid
//  cmd_wdata  in   12     write data
//  rsp_valid  out  1      response available; held until rsp_ready
//  rsp_ready  in   1      response consumed when rsp_valid&&rsp_ready
//  rsp_rdata  out  12     read/readback data; 0 for plain writes
//  rsp_err    out  1      bad address or verify mismatch
//  err_cnt    out  ERRW   count of rsp_err responses, saturates at all-ones
//  SSP_SSEL   out  1      slave select
//  SSP_RA     out  3      register address
//  SSP_WnR    out  1      1 write, 0 read
//  SSP_DI     out  12     write data to slave
//  SSP_EOC    out  1      end-of-cycle strobe, 1 cycle wide
//  SSP_DO     in   12     read data from slave
// BEHAVIOUR
//  - Reset: all outputs registered, all 0 (including cmd_ready); state IDLE. cmd_ready=1 from the first edge after Rst_n rises.
//  - States: IDLE, SETUP, STROBE, WAIT, RESP.
//  - IDLE: cmd_ready=1, SSEL=0, EOC=0.
//      - On accept: latch op/ra/wdata.
//      - ra>4: go to RESP with rsp_err=1, no SSP activity (rsp_valid at accept+1).
//      - Otherwise go to SETUP.
//  - SETUP (1 cycle): SSEL=1; RA/WnR/DI driven, stable through STROBE/WAIT; EOC=0.
//  - STROBE (1 cycle): SSEL=1, EOC=1.
//      - Write: go to RESP, or for write-verify go to SETUP with WnR=0.
//      - Read: go to WAIT.
//  - WAIT: RD_LAT cycles, SSEL=1, EOC=0. SSP_DO sampled at the final WAIT edge into rsp_rdata; go to RESP.
//  - RESP: SSEL=0, rsp_valid=1. rsp_* held stable until rsp_ready; then IDLE.
//      - cmd_ready=0 in every non-IDLE state.
//  - Latency (accept edge = cycle 0, rsp_valid first high):
//      - write: cycle 3
//      - read: cycle 3+RD_LAT
//      - write-verify: cycle 5+RD_LAT (7 at default)
//  - Verify: rsp_err=1 iff captured SSP_DO != latched wdata (4-state compare; X counts as mismatch).
//  - err_cnt: +1 on each RESP entry with rsp_err=1; holds at 2^ERRW-1.
//  - At least one SSEL-low cycle (RESP+IDLE) between back-to-back transactions. Commands are never pipelined.
//  - Rst_n low mid-transaction: SSEL/EOC/all outputs drop to 0 asynchronously. In-flight command discarded, no response, err_cnt cleared.
// STRUCTURE
//  - ssp_master_pkg:
//      - register address localparams UCR=0, USR=1, RDR=2, TDR=3, SPR=4
//      - op enum (OP_RD, OP_WR, OP_WRV)
//      - state enum
//      - RA_MAX=4
//  - Single module. WAIT counter ($clog2(RD_LAT+1) bits) and the verify-phase flag live inside; no sub-module.
// TESTING
//  1. Write UCR 0xDED -> SETUP c1, STROBE c2 (SSEL=1, RA=0, WnR=1, DI=DED, EOC=1), rsp_valid c3, rsp_err=0.
//  2. After reset, read RA 0..4 with reset-valued responder -> rsp_rdata=0x000 each, rsp_valid at c5.
//  3. Write-verify SPR 0xA5A against echo responder -> rsp_err=0, rsp_rdata=A5A. Corrupted readback 0xA5B -> rsp_err=1, err_cnt=1.
//  4. cmd_ra=5 -> SSP_SSEL never rises, rsp_valid c1, rsp_err=1, err_cnt increments.
//  5. rsp_ready held low 5 cycles -> rsp_valid/rdata stable, cmd_ready=0, concurrent cmd_valid not accepted.
//  6. Rst_n low during WAIT -> SSEL/EOC 0 same timestep, no rsp_valid; cmd_ready=1 one edge after release.

Source files
------------

// File: rtl/ssp_master_pkg.sv
// Shared types and constants for the SSP register-bus command master.
// Register map of ssp_uart, command opcodes and the sequencer state set.
package ssp_master_pkg;

  localparam int unsigned DW = 12;

  localparam logic [2:0] UCR    = 3'd0;
  localparam logic [2:0] USR    = 3'd1;
  localparam logic [2:0] RDR    = 3'd2;
  localparam logic [2:0] TDR    = 3'd3;
  localparam logic [2:0] SPR    = 3'd4;
  localparam logic [2:0] RA_MAX = SPR;

  typedef enum logic [1:0] {
    OP_RD  = 2'b00,
    OP_WR  = 2'b01,
    OP_WRV = 2'b10
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_WAIT,
    ST_RESP
  } state_e;

  // The reserved encoding 2'b11 behaves as a plain read.
  function automatic op_e decode_op(input logic [1:0] raw);
    case (raw)
      2'b01:   return OP_WR;
      2'b10:   return OP_WRV;
      default: return OP_RD;
    endcase
  endfunction

endpackage

// File: rtl/ssp_cmd_master_if.sv
// Command/response handshake bundle between a host fabric and ssp_cmd_master.
// The host side uses the master modport, the sequencer uses the slave modport.
interface ssp_cmd_master_if;
  import ssp_master_pkg::*;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [2:0]    cmd_ra;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_ra, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_ra, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/ssp_cmd_master.sv
// Sequences read / write / write-verify commands onto the ssp_uart register bus
// and returns one registered response per command. All outputs are registered.
module ssp_cmd_master
  import ssp_master_pkg::*;
#(
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned ERRW   = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  ssp_cmd_master_if.slave  cmd,
  output logic [ERRW-1:0]  err_cnt,
  output logic             SSP_SSEL,
  output logic [2:0]       SSP_RA,
  output logic             SSP_WnR,
  output logic [DW-1:0]    SSP_DI,
  output logic             SSP_EOC,
  input  logic [DW-1:0]    SSP_DO
);

  localparam int unsigned CW = $clog2(RD_LAT + 1);

  state_e          state_q, state_n;
  op_e             op_q, op_n;
  logic            verify_q, verify_n;
  logic [CW-1:0]   wait_q, wait_n;

  logic            ready_q, ready_n;
  logic            ssel_q, ssel_n;
  logic            eoc_q, eoc_n;
  logic            wnr_q, wnr_n;
  logic [2:0]      sra_q, sra_n;
  logic [DW-1:0]   di_q, di_n;
  logic            rsp_valid_q, rsp_valid_n;
  logic [DW-1:0]   rdata_q, rdata_n;
  logic            err_q, err_n;
  logic [ERRW-1:0] ecnt_q, ecnt_n;
  logic            bump;

  // Outputs are registered from the next-state decode, so each state's bus
  // values are visible during the cycle that state occupies.
  always_comb begin
    state_n     = state_q;
    op_n        = op_q;
    verify_n    = verify_q;
    wait_n      = wait_q;
    ssel_n      = ssel_q;
    eoc_n       = 1'b0;
    wnr_n       = wnr_q;
    sra_n       = sra_q;
    di_n        = di_q;
    rsp_valid_n = rsp_valid_q;
    rdata_n     = rdata_q;
    err_n       = err_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd.cmd_valid && ready_q) begin
          op_n     = decode_op(cmd.cmd_op);
          verify_n = 1'b0;
          rdata_n  = '0;
          err_n    = 1'b0;
          if (cmd.cmd_ra > RA_MAX) begin
            state_n     = ST_RESP;
            rsp_valid_n = 1'b1;
            err_n       = 1'b1;
          end else begin
            state_n = ST_SETUP;
            ssel_n  = 1'b1;
            sra_n   = cmd.cmd_ra;
            wnr_n   = (decode_op(cmd.cmd_op) != OP_RD);
            di_n    = cmd.cmd_wdata;
          end
        end
      end

      ST_SETUP: begin
        state_n = ST_STROBE;
        eoc_n   = 1'b1;
      end

      ST_STROBE: begin
        if (wnr_q) begin
          if (op_q == OP_WRV) begin
            state_n  = ST_SETUP;
            verify_n = 1'b1;
            wnr_n    = 1'b0;
          end else begin
            state_n     = ST_RESP;
            ssel_n      = 1'b0;
            rsp_valid_n = 1'b1;
          end
        end else begin
          state_n = ST_WAIT;
          wait_n  = CW'(RD_LAT);
        end
      end

      ST_WAIT: begin
        if (wait_q == CW'(1)) begin
          state_n     = ST_RESP;
          ssel_n      = 1'b0;
          rsp_valid_n = 1'b1;
          rdata_n     = SSP_DO;
          // 4-state compare so an undriven readback is flagged as a mismatch.
          err_n       = verify_q && (SSP_DO !== di_q);
        end else begin
          wait_n = wait_q - CW'(1);
        end
      end

      ST_RESP: begin
        if (rsp_valid_q && cmd.rsp_ready) begin
          state_n     = ST_IDLE;
          rsp_valid_n = 1'b0;
        end
      end

      default: state_n = ST_IDLE;
    endcase

    ready_n = (state_n == ST_IDLE);
    bump    = (state_q != ST_RESP) && (state_n == ST_RESP) && err_n;
    ecnt_n  = (bump && (ecnt_q != '1)) ? ecnt_q + 1'b1 : ecnt_q;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_RD;
      verify_q    <= 1'b0;
      wait_q      <= '0;
      ready_q     <= 1'b0;
      ssel_q      <= 1'b0;
      eoc_q       <= 1'b0;
      wnr_q       <= 1'b0;
      sra_q       <= '0;
      di_q        <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      ecnt_q      <= '0;
    end else begin
      state_q     <= state_n;
      op_q        <= op_n;
      verify_q    <= verify_n;
      wait_q      <= wait_n;
      ready_q     <= ready_n;
      ssel_q      <= ssel_n;
      eoc_q       <= eoc_n;
      wnr_q       <= wnr_n;
      sra_q       <= sra_n;
      di_q        <= di_n;
      rsp_valid_q <= rsp_valid_n;
      rdata_q     <= rdata_n;
      err_q       <= err_n;
      ecnt_q      <= ecnt_n;
    end
  end

  assign cmd.cmd_ready = ready_q;
  assign cmd.rsp_valid = rsp_valid_q;
  assign cmd.rsp_rdata = rdata_q;
  assign cmd.rsp_err   = err_q;
  assign err_cnt       = ecnt_q;
  assign SSP_SSEL      = ssel_q;
  assign SSP_RA        = sra_q;
  assign SSP_WnR       = wnr_q;
  assign SSP_DI        = di_q;
  assign SSP_EOC       = eoc_q;

endmodule

// File: tb/tb_ssp_cmd_master.sv
// Scoreboard bench for ssp_cmd_master: randomized commands against a register-file
// model, with an ssp_uart-like responder that presents read data RD_LAT cycles after EOC.
module tb_ssp_cmd_master;
  import ssp_master_pkg::*;

  localparam int RD_LAT = 2;
  localparam int ERRW   = 4;
  localparam int EMAX   = (1 << ERRW) - 1;

  logic Clk   = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  ssp_cmd_master_if bus();

  logic [ERRW-1:0] err_cnt;
  logic            SSP_SSEL, SSP_WnR, SSP_EOC;
  logic [2:0]      SSP_RA;
  logic [11:0]     SSP_DI;
  logic [11:0]     SSP_DO;

  ssp_cmd_master #(.RD_LAT(RD_LAT), .ERRW(ERRW)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .cmd(bus), .err_cnt(err_cnt),
    .SSP_SSEL(SSP_SSEL), .SSP_RA(SSP_RA), .SSP_WnR(SSP_WnR),
    .SSP_DI(SSP_DI), .SSP_EOC(SSP_EOC), .SSP_DO(SSP_DO)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]      ra;
    logic [11:0]     wd;
    logic            wnr1;
    logic [11:0]     rdata;
    logic            err;
    logic [ERRW-1:0] ecnt;
    int              lat;
    int              ssel;
    int              eocs;
    int              acc;
  } exp_t;

  exp_t        q[$];
  logic [11:0] mem_m[5];
  logic [11:0] mem_s[5];
  int          ecnt_m;
  int          cyc;
  logic        hs_pend;
  logic [11:0] next_mask;
  logic [11:0] cur_mask;
  logic        force_hold;

  // Handshake prediction at the falling edge; inputs are stable until the next rising edge.
  initial begin
    hs_pend = 1'b0;
    forever begin
      @(negedge Clk);
      hs_pend = bus.cmd_valid && bus.cmd_ready && Rst_n;
    end
  end

  // Reference model: executes each accepted command against an abstract register file.
  initial begin
    exp_t e;
    int   opx;
    for (int i = 0; i < 5; i++) mem_m[i] = '0;
    ecnt_m   = 0;
    cur_mask = '0;
    forever begin
      @(posedge Clk or negedge Rst_n);
      if (!Rst_n) begin
        ecnt_m = 0;
      end else if (hs_pend) begin
        e.ra   = bus.cmd_ra;
        e.wd   = bus.cmd_wdata;
        e.acc  = cyc;
        opx    = (bus.cmd_op == 2'b11) ? 0 : int'(bus.cmd_op);
        e.wnr1 = (opx != 0);
        cur_mask = (opx == 2) ? next_mask : 12'h000;
        if (e.ra > 3'd4) begin
          e.rdata = '0; e.err = 1'b1; e.lat = 1; e.ssel = 0; e.eocs = 0;
        end else if (opx == 0) begin
          e.rdata = mem_m[e.ra]; e.err = 1'b0; e.lat = 3 + RD_LAT; e.ssel = 2 + RD_LAT; e.eocs = 1;
        end else if (opx == 1) begin
          mem_m[e.ra] = e.wd;
          e.rdata = '0; e.err = 1'b0; e.lat = 3; e.ssel = 2; e.eocs = 1;
        end else begin
          mem_m[e.ra] = e.wd ^ cur_mask;
          e.rdata = mem_m[e.ra]; e.err = (cur_mask != 0); e.lat = 5 + RD_LAT; e.ssel = 4 + RD_LAT; e.eocs = 2;
        end
        if (e.err && ecnt_m < EMAX) ecnt_m++;
        e.ecnt = ERRW'(ecnt_m);
        q.push_back(e);
      end
    end
  end

  // Slave responder: stores writes (optionally corrupted), drives read data only in the sample cycle.
  initial begin
    int         rd_cnt;
    logic [2:0] rd_ra;
    for (int i = 0; i < 5; i++) mem_s[i] = '0;
    rd_cnt = 0;
    rd_ra  = '0;
    SSP_DO = 12'h000;
    forever begin
      @(posedge Clk);
      if (SSP_EOC && SSP_SSEL) begin
        if (SSP_WnR && SSP_RA <= 3'd4) mem_s[SSP_RA] = SSP_DI ^ cur_mask;
        else if (!SSP_WnR) begin rd_cnt = RD_LAT; rd_ra = SSP_RA; end
      end else if (rd_cnt > 0) rd_cnt--;
      #1;
      if (rd_cnt == 1 && rd_ra <= 3'd4) SSP_DO = mem_s[rd_ra];
      else SSP_DO = 12'($urandom);
    end
  end

  // Monitor: protocol checks on the SSP bus and scoreboard compare on each response.
  initial begin
    exp_t        e;
    logic        have, prev_eoc;
    int          ssel_cnt, eoc_cnt, hold;
    logic [11:0] hrd;
    logic        herr;
    cyc = 0; have = 0; prev_eoc = 0; ssel_cnt = 0; eoc_cnt = 0; hold = 0;
    hrd = '0; herr = 0;
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge Clk);
      #1;
      cyc++;
      if (!Rst_n) begin
        q.delete();
        have = 0; prev_eoc = 0; ssel_cnt = 0; eoc_cnt = 0;
        bus.rsp_ready = 1'b0;
        continue;
      end
      if (SSP_SSEL) ssel_cnt++;
      if (SSP_EOC) begin
        eoc_cnt++;
        chk("eoc_with_ssel", SSP_SSEL, 1);
        chk("eoc_one_cycle", prev_eoc, 0);
        if (q.size() == 0) chk("eoc_without_cmd", 1, 0);
        else begin
          chk("ssp_ra", SSP_RA, q[0].ra);
          chk("ssp_wnr", SSP_WnR, (eoc_cnt == 1) ? q[0].wnr1 : 1'b0);
          if (eoc_cnt == 1 && q[0].wnr1) chk("ssp_di", SSP_DI, q[0].wd);
        end
      end
      prev_eoc = SSP_EOC;
      if (have && bus.rsp_ready) begin
        chk("rsp_drop_after_ready", bus.rsp_valid, 0);
        have = 0;
        bus.rsp_ready = 1'b0;
        continue;
      end
      if (bus.rsp_valid) begin
        if (!have) begin
          if (q.size() == 0) begin
            chk("unexpected_rsp", bus.rsp_valid, 0);
            bus.rsp_ready = 1'b1;
            continue;
          end
          e = q.pop_front();
          have = 1;
          chk("rsp_rdata", bus.rsp_rdata, e.rdata);
          chk("rsp_err", bus.rsp_err, e.err);
          chk("rsp_latency", cyc - e.acc, e.lat);
          chk("err_cnt", err_cnt, e.ecnt);
          chk("ssel_cycles", ssel_cnt, e.ssel);
          chk("eoc_pulses", eoc_cnt, e.eocs);
          chk("ssel_low_in_resp", SSP_SSEL, 0);
          chk("cmd_ready_busy", bus.cmd_ready, 0);
          hrd = bus.rsp_rdata; herr = bus.rsp_err;
          ssel_cnt = 0; eoc_cnt = 0;
          hold = force_hold ? 5 : $urandom_range(0, 3);
        end else begin
          chk("rsp_rdata_stable", bus.rsp_rdata, hrd);
          chk("rsp_err_stable", bus.rsp_err, herr);
          chk("cmd_ready_hold", bus.cmd_ready, 0);
        end
        if (hold == 0) bus.rsp_ready = 1'b1;
        else begin hold--; bus.rsp_ready = 1'b0; end
      end else begin
        bus.rsp_ready = 1'b0;
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [2:0] ra, input logic [11:0] wd, input logic [11:0] mask);
    int n;
    next_mask     = mask;
    bus.cmd_op    = op;
    bus.cmd_ra    = ra;
    bus.cmd_wdata = wd;
    bus.cmd_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge Clk);
      if (bus.cmd_ready) break;
      n++;
      if (n > 200) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge Clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      if (q.size() == 0 && !bus.rsp_valid && bus.cmd_ready) return;
      @(posedge Clk);
      #1;
    end
    chk("drain_timeout", 0, 1);
  endtask

  task automatic random_cmds(input int n);
    logic [11:0] m;
    for (int i = 0; i < n; i++) begin
      m = ($urandom_range(0, 2) == 0) ? 12'($urandom) : 12'h000;
      issue(2'($urandom), 3'($urandom), 12'($urandom), m);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_ra    = 3'd0;
    bus.cmd_wdata = 12'h000;
    next_mask     = 12'h000;
    force_hold    = 1'b0;

    #1;
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_ssel", SSP_SSEL, 0);
    chk("rst_eoc", SSP_EOC, 0);
    chk("rst_err_cnt", err_cnt, 0);
    #11 Rst_n = 1'b1;
    #1 chk("cmd_ready_before_edge", bus.cmd_ready, 0);
    @(posedge Clk); #1;
    chk("cmd_ready_first_edge", bus.cmd_ready, 1);

    for (int r = 0; r < 5; r++) issue(OP_RD, 3'(r), 12'h000, 12'h000);
    issue(OP_WR, UCR, 12'hDED, 12'h000);
    issue(OP_RD, UCR, 12'h000, 12'h000);
    issue(OP_WRV, SPR, 12'hA5A, 12'h000);
    issue(OP_WRV, SPR, 12'hA5A, 12'h001);
    issue(OP_RD, 3'd5, 12'h123, 12'h000);
    issue(OP_WR, 3'd7, 12'h456, 12'h000);
    issue(2'b11, TDR, 12'h000, 12'h000);
    drain();

    force_hold = 1'b1;
    issue(OP_WR, RDR, 12'h3C3, 12'h000);
    issue(OP_RD, RDR, 12'h000, 12'h000);
    drain();
    force_hold = 1'b0;

    random_cmds(150);
    drain();

    issue(OP_RD, USR, 12'h000, 12'h000);
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk); #1;
      if (SSP_EOC) break;
    end
    @(posedge Clk);
    #2 Rst_n = 1'b0;
    #1;
    chk("abort_ssel", SSP_SSEL, 0);
    chk("abort_eoc", SSP_EOC, 0);
    chk("abort_rsp_valid", bus.rsp_valid, 0);
    chk("abort_err_cnt", err_cnt, 0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    #1 chk("abort_ready_before_edge", bus.cmd_ready, 0);
    @(posedge Clk); #1;
    chk("abort_ready_after_edge", bus.cmd_ready, 1);
    repeat (8) @(posedge Clk);
    #1 chk("abort_no_rsp", bus.rsp_valid, 0);

    random_cmds(30);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
